// File: rtl/seq_mag_comparator_pkg.sv
// Shared encodings for the multi-cycle magnitude comparator.
// FSM state codes and latched result codes.
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_GT   = 2'd1;
  localparam logic [1:0] R_EQ   = 2'd2;
  localparam logic [1:0] R_LT   = 2'd3;

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational greater/less compare of one DIGIT-bit digit.
// Used on the top digit of the comparator shift registers.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o
);

  assign gt_o = a_i > b_i;
  assign lt_o = a_i < b_i;

endmodule

// File: rtl/seq_mag_comparator.sv
// MSB-first digit-serial magnitude comparator, valid/ready both sides.
// Define CMP_SIGNED_EN to add the sgn port (two's-complement compare).
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       res_q, res_d;
  logic [WIDTH-1:0] flip;
  logic             dgt, dlt;

  always_comb begin
    flip = '0;
`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    flip[WIDTH-1] = sgn;
`endif
  end

  digit_cmp #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_i (a_q[WIDTH-1 -: DIGIT]),
    .b_i (b_q[WIDTH-1 -: DIGIT]),
    .gt_o(dgt),
    .lt_o(dlt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a ^ flip;
          b_d     = b ^ flip;
          cnt_d   = CW'(NDIG - 1);
          res_d   = R_NONE;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // First difference wins; later digits never overwrite it.
        if (res_q == R_NONE && (dgt || dlt))
          res_d = dgt ? R_GT : R_LT;
        if (res_q == R_NONE && (dgt || dlt) && EARLY_EXIT) begin
          state_d = S_DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_DONE;
            if (res_d == R_NONE)
              res_d = R_EQ;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          res_d   = R_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= R_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign agtb      = out_valid && (res_q == R_GT);
  assign aeqb      = out_valid && (res_q == R_EQ);
  assign altb      = out_valid && (res_q == R_LT);

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench: early-exit and fixed-latency comparators driven in parallel.
// Scoreboard holds expected flags and latency per accepted operand pair.
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic ir0, ov0, g0, e0, l0, bz0;
  logic ir1, ov1, g1, e1, l1, bz1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_mag_comparator #(
    .WIDTH(16), .DIGIT(2), .EARLY_EXIT(1'b1)
  ) u_early (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b),
`ifdef CMP_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(ov0), .out_ready(out_ready),
    .agtb(g0), .aeqb(e0), .altb(l0), .busy(bz0)
  );

  seq_mag_comparator #(
    .WIDTH(16), .DIGIT(2), .EARLY_EXIT(1'b0)
  ) u_fixed (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b),
`ifdef CMP_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(ov1), .out_ready(out_ready),
    .agtb(g1), .aeqb(e1), .altb(l1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int first_diff(input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < 8; i++)
      if (x[15-2*i -: 2] != y[15-2*i -: 2]) return i + 1;
    return 8;
  endfunction

  task automatic push_exp(input logic [15:0] xa, input logic [15:0] xb,
                          input logic xs);
    exp_t        e;
    logic [15:0] ta;
    logic [15:0] tb;
    ta = xa;
    tb = xb;
    if (xs) begin
      ta[15] = ~ta[15];
      tb[15] = ~tb[15];
      e.gt = $signed(xa) > $signed(xb);
      e.lt = $signed(xa) < $signed(xb);
    end else begin
      e.gt = xa > xb;
      e.lt = xa < xb;
    end
    e.eq  = xa == xb;
    e.lat = first_diff(ta, tb);
    sb.push_back(e);
  endtask

  task automatic accept(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xs);
    @(negedge clk);
    a = xa;
    b = xb;
    sgn = xs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_results(input string tag, output int lat0,
                              output int lat1);
    lat0 = -1;
    lat1 = -1;
    for (int c = 1; c <= 40 && (lat0 < 0 || lat1 < 0); c++) begin
      @(posedge clk);
      #1;
      if (lat0 < 0 && ov0) lat0 = c;
      if (lat1 < 0 && ov1) lat1 = c;
    end
    chk({tag, "/timeout"}, 32'(lat0 > 0 && lat1 > 0), 32'd1);
  endtask

  task automatic check_results(input string tag, input int lat0,
                               input int lat1);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "/lat_early"}, lat0, e.lat);
    chk({tag, "/lat_fixed"}, lat1, 8);
    chk({tag, "/flags_early"}, {g0, e0, l0}, {e.gt, e.eq, e.lt});
    chk({tag, "/flags_fixed"}, {g1, e1, l1}, {e.gt, e.eq, e.lt});
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "/idle_early"}, {ov0, g0, e0, l0, bz0, ir0}, 6'b000001);
    chk({tag, "/idle_fixed"}, {ov1, g1, e1, l1, bz1, ir1}, 6'b000001);
  endtask

  task automatic xact(input logic [15:0] xa, input logic [15:0] xb,
                      input logic xs, input string tag);
    int lat0, lat1;
    push_exp(xa, xb, xs);
    accept(xa, xb, xs);
    chk({tag, "/busy"}, {bz0, bz1, ir0, ir1}, 4'b1100);
    wait_results(tag, lat0, lat1);
    check_results(tag, lat0, lat1);
    release_out(tag);
  endtask

  initial begin
    int   lat0, lat1;
    logic stale;

    #12;
    chk("reset_early", {ir0, ov0, g0, e0, l0, bz0}, 6'b100000);
    chk("reset_fixed", {ir1, ov1, g1, e1, l1, bz1}, 6'b100000);
    @(negedge clk);
    rst_n = 1'b1;

    xact(16'h8000, 16'h7FFF, 1'b0, "msb_gt");
    xact(16'h1234, 16'h1234, 1'b0, "equal");
    xact(16'h0001, 16'h0002, 1'b0, "lsb_lt");
    xact(16'h0000, 16'hFFFF, 1'b0, "zero_max");
    xact(16'h1230, 16'h1330, 1'b0, "mid_lt");
    for (int i = 0; i < 4; i++)
      xact(16'($urandom), 16'($urandom), 1'b0, "random");

    // Output stall with competing input traffic.
    push_exp(16'h00F0, 16'h0F00, 1'b0);
    accept(16'h00F0, 16'h0F00, 1'b0);
    wait_results("stall", lat0, lat1);
    check_results("stall", lat0, lat1);
    @(negedge clk);
    a = 16'h5555;
    b = 16'hAAAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold_early", {ov0, g0, e0, l0, ir0}, 5'b10010);
      chk("stall_hold_fixed", {ov1, g1, e1, l1, ir1}, 5'b10010);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall_idle_early", {ov0, g0, e0, l0, bz0, ir0}, 6'b000001);
    chk("stall_idle_fixed", {ov1, g1, e1, l1, bz1, ir1}, 6'b000001);
    xact(16'h0003, 16'h0003, 1'b0, "after_stall");

    // Reset mid-run abandons the operation.
    accept(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy", {bz0, bz1, ov0, ov1}, 4'b1100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_run_early", {ir0, ov0, g0, e0, l0, bz0}, 6'b100000);
    chk("reset_run_fixed", {ir1, ov1, g1, e1, l1, bz1}, 6'b100000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ov0 || ov1 || bz0 || bz1) stale = 1'b1;
    end
    chk("no_stale", 32'(stale), 32'd0);
    xact(16'h4000, 16'h3FFF, 1'b0, "after_reset");

`ifdef CMP_SIGNED_EN
    xact(16'hFFFF, 16'h0001, 1'b1, "signed_lt");
    xact(16'hFFFF, 16'h0001, 1'b0, "unsigned_gt");
    xact(16'h8000, 16'h7FFF, 1'b1, "signed_min");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
